// File: rtl/regfile_mp_if.sv
// Bus bundle between decode/writeback and the multi-port register file.
// Read addresses/data are flattened, port i at [i*AW +: AW] and [i*DW +: DW].
interface regfile_mp_if #(
   parameter int DW     = 64,
   parameter int AW     = 5,
   parameter int NUM_RD = 2
);
   logic [NUM_RD*AW-1:0] RAddr;
   logic [NUM_RD*DW-1:0] RData;
   logic [NUM_RD-1:0]    RBusy;
   logic                 WE0;
   logic [AW-1:0]        WAddr0;
   logic [DW-1:0]        WData0;
   logic                 WE1;
   logic [AW-1:0]        WAddr1;
   logic [DW-1:0]        WData1;
   logic                 BusySet;
   logic [AW-1:0]        BusyAddr;

   modport master (
      output RAddr, WE0, WAddr0, WData0, WE1, WAddr1, WData1, BusySet, BusyAddr,
      input  RData, RBusy
   );

   modport slave (
      input  RAddr, WE0, WAddr0, WData0, WE1, WAddr1, WData1, BusySet, BusyAddr,
      output RData, RBusy
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD combinational
// read ports, optional hard-wired zero register, optional bypass, busy scoreboard.
module regfile_mp #(
   parameter int DW       = 64,
   parameter int DEPTH    = 32,
   parameter int NUM_RD   = 2,
   parameter int ZERO_EN  = 1,
   parameter int ZERO_IDX = 31,
   parameter int BYPASS   = 1
) (
   input  logic         Clk,
   input  logic         Rst_n,
   regfile_mp_if.slave  bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0]    mem [DEPTH];
   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_nxt;
   logic             w0_ok;
   logic             w1_ok;

   // Addresses that own real storage: in range and not the zero register.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      addr_ok = (int'(a) < DEPTH) && !((ZERO_EN != 0) && (int'(a) == ZERO_IDX));
   endfunction

   assign w1_ok = bus.WE1 && addr_ok(bus.WAddr1);
   assign w0_ok = bus.WE0 && addr_ok(bus.WAddr0) &&
                  !(bus.WE1 && (bus.WAddr1 == bus.WAddr0));

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (w0_ok) mem[bus.WAddr0] <= bus.WData0;
         if (w1_ok) mem[bus.WAddr1] <= bus.WData1;
      end
   end

   // Retiring writes clear first so a same-cycle BusySet (new producer) wins.
   always_comb begin
      busy_nxt = busy;
      if (bus.WE0 && addr_ok(bus.WAddr0)) busy_nxt[bus.WAddr0] = 1'b0;
      if (bus.WE1 && addr_ok(bus.WAddr1)) busy_nxt[bus.WAddr1] = 1'b0;
      if (bus.BusySet && addr_ok(bus.BusyAddr)) busy_nxt[bus.BusyAddr] = 1'b1;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) busy <= '0;
      else        busy <= busy_nxt;
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      logic          rb;

      assign ra = bus.RAddr[i*AW +: AW];

      always_comb begin
         rd = '0;
         rb = 1'b0;
         if (Rst_n && addr_ok(ra)) begin
            rd = mem[ra];
            rb = busy[ra];
            if (BYPASS != 0) begin
               if (bus.WE0 && (bus.WAddr0 == ra)) begin
                  rd = bus.WData0;
                  rb = 1'b0;
               end
               if (bus.WE1 && (bus.WAddr1 == ra)) begin
                  rd = bus.WData1;
                  rb = 1'b0;
               end
            end
         end
      end

      assign bus.RData[i*DW +: DW] = rd;
      assign bus.RBusy[i]          = rb;
   end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default build (bypass, zero reg) and a
// DEPTH=24 / NUM_RD=4 / no-bypass build driven from the same stimulus.
module tb_regfile_mp;
   localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        Clk;
   logic        Rst_n;
   logic        we0, we1, bset;
   logic [4:0]  wa0, wa1, ba;
   logic [63:0] wd0, wd1;
   logic [4:0]  ra [4];

   int n_chk;
   int n_err;

   regfile_mp_if #(.DW(64), .AW(5), .NUM_RD(2)) ifa ();
   regfile_mp_if #(.DW(64), .AW(5), .NUM_RD(4)) ifb ();

   assign ifa.RAddr    = {ra[1], ra[0]};
   assign ifb.RAddr    = {ra[3], ra[2], ra[1], ra[0]};
   assign ifa.WE0      = we0;
   assign ifa.WAddr0   = wa0;
   assign ifa.WData0   = wd0;
   assign ifa.WE1      = we1;
   assign ifa.WAddr1   = wa1;
   assign ifa.WData1   = wd1;
   assign ifa.BusySet  = bset;
   assign ifa.BusyAddr = ba;
   assign ifb.WE0      = we0;
   assign ifb.WAddr0   = wa0;
   assign ifb.WData0   = wd0;
   assign ifb.WE1      = we1;
   assign ifb.WAddr1   = wa1;
   assign ifb.WData1   = wd1;
   assign ifb.BusySet  = bset;
   assign ifb.BusyAddr = ba;

   regfile_mp dut_a (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (ifa)
   );

   regfile_mp #(
      .DW(64), .DEPTH(24), .NUM_RD(4), .ZERO_EN(0), .ZERO_IDX(0), .BYPASS(0)
   ) dut_b (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (ifb)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic        we0;
      logic [4:0]  wa0;
      logic [63:0] wd0;
      logic        we1;
      logic [4:0]  wa1;
      logic [63:0] wd1;
      logic        bset;
      logic [4:0]  ba;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [63:0] rd0;
      logic [63:0] rd1;
      logic        rb0;
      logic        rb1;
   } vec_t;

   vec_t vecs [14];

   function automatic vec_t mkv(input int e0, input int a0, input longint d0,
                                input int e1, input int a1, input longint d1,
                                input int bs, input int bad,
                                input int r0, input int r1,
                                input longint x0, input longint x1,
                                input int b0, input int b1);
      vec_t v;
      v.we0 = e0[0];   v.wa0 = a0[4:0]; v.wd0 = d0;
      v.we1 = e1[0];   v.wa1 = a1[4:0]; v.wd1 = d1;
      v.bset = bs[0];  v.ba = bad[4:0];
      v.ra0 = r0[4:0]; v.ra1 = r1[4:0];
      v.rd0 = x0;      v.rd1 = x1;
      v.rb0 = b0[0];   v.rb1 = b1[0];
      return v;
   endfunction

   task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic drive(input logic e0, input logic [4:0] a0, input logic [63:0] d0,
                        input logic e1, input logic [4:0] a1, input logic [63:0] d1,
                        input logic bs, input logic [4:0] bad);
      we0 = e0; wa0 = a0; wd0 = d0;
      we1 = e1; wa1 = a1; wd1 = d1;
      bset = bs; ba = bad;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      Rst_n = 1'b0;
      idle();
      for (int i = 0; i < 4; i++) ra[i] = 5'd0;

      vecs[0]  = mkv(0, 0, 0,        0, 0, 0,        0, 0,   0, 31, 0,        0,        0, 0);
      vecs[1]  = mkv(1, 3, 'h1111,   1, 3, 'h2222,   0, 0,   3, 4,  'h2222,   0,        0, 0);
      vecs[2]  = mkv(1, 4, 'hA,      1, 6, 'hB,      0, 0,   3, 4,  'h2222,   'hA,      0, 0);
      vecs[3]  = mkv(0, 0, 0,        0, 0, 0,        0, 0,   4, 6,  'hA,      'hB,      0, 0);
      vecs[4]  = mkv(1, 31, -1,      1, 30, -1,      1, 31,  31, 30, 0,       -1,       0, 0);
      vecs[5]  = mkv(0, 0, 0,        0, 0, 0,        0, 0,   31, 30, 0,       -1,       0, 0);
      vecs[6]  = mkv(0, 0, 0,        1, 7, 'h77,     0, 0,   7, 3,  'h77,     'h2222,   0, 0);
      vecs[7]  = mkv(0, 0, 0,        0, 0, 0,        1, 9,   9, 7,  0,        'h77,     0, 0);
      vecs[8]  = mkv(1, 9, 'h99,     0, 0, 0,        1, 9,   9, 9,  'h99,     'h99,     0, 0);
      vecs[9]  = mkv(0, 0, 0,        0, 0, 0,        0, 0,   9, 8,  'h99,     0,        1, 0);
      vecs[10] = mkv(0, 0, 0,        1, 9, 'hAA,     0, 0,   9, 10, 'hAA,     0,        0, 0);
      vecs[11] = mkv(0, 0, 0,        0, 0, 0,        0, 0,   9, 30, 'hAA,     -1,       0, 0);
      vecs[12] = mkv(1, 13, 'h13,    0, 0, 0,        1, 12,  12, 13, 0,       'h13,     0, 0);
      vecs[13] = mkv(0, 0, 0,        0, 0, 0,        0, 0,   12, 13, 0,       'h13,     1, 0);

      tick();
      tick();
      Rst_n = 1'b1;

      // Post-reset sweep: every address on both ports reads zero, not busy.
      for (int a = 0; a < 32; a++) begin
         ra[0] = 5'(a);
         ra[1] = 5'(31 - a);
         #1;
         chk64("rst_rd0", ifa.RData[63:0], 64'd0);
         chk64("rst_rd1", ifa.RData[127:64], 64'd0);
         chk1("rst_rb0", ifa.RBusy[0], 1'b0);
         chk1("rst_rb1", ifa.RBusy[1], 1'b0);
      end
      tick();

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].we0, vecs[i].wa0, vecs[i].wd0, vecs[i].we1, vecs[i].wa1,
               vecs[i].wd1, vecs[i].bset, vecs[i].ba);
         ra[0] = vecs[i].ra0;
         ra[1] = vecs[i].ra1;
         #2;
         chk64($sformatf("v%0d_rd0", i), ifa.RData[63:0], vecs[i].rd0);
         chk64($sformatf("v%0d_rd1", i), ifa.RData[127:64], vecs[i].rd1);
         chk1($sformatf("v%0d_rb0", i), ifa.RBusy[0], vecs[i].rb0);
         chk1($sformatf("v%0d_rb1", i), ifa.RBusy[1], vecs[i].rb1);
         tick();
      end

      // Mid-run asynchronous reset, with writes pending while it is low.
      drive(1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
      ra[0] = 5'd5;
      ra[1] = 5'd6;
      tick();
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd5);
      #2;
      chk64("pre_rst_r5", ifa.RData[63:0], 64'hDEAD);
      chk64("pre_rst_b_r5", ifb.RData[63:0], 64'hDEAD);
      tick();
      #2;
      chk1("pre_rst_busy5", ifa.RBusy[0], 1'b1);
      drive(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0, 1'b1, 5'd5);
      Rst_n = 1'b0;
      #1;
      chk64("arst_r5", ifa.RData[63:0], 64'd0);
      chk1("arst_busy5", ifa.RBusy[0], 1'b0);
      chk64("arst_r6", ifa.RData[127:64], 64'd0);
      chk64("arst_b_r5", ifb.RData[63:0], 64'd0);
      tick();
      idle();
      #1;
      Rst_n = 1'b1;
      #1;
      chk64("post_rst_r5", ifa.RData[63:0], 64'd0);
      chk1("post_rst_busy5", ifa.RBusy[0], 1'b0);
      chk64("post_rst_b_r5", ifb.RData[63:0], 64'd0);
      tick();

      // No-bypass build: same-cycle write is invisible and busy is not forced.
      drive(1'b1, 5'd7, 64'h55, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
      ra[0] = 5'd7;
      tick();
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7);
      tick();
      drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h77, 1'b0, 5'd0);
      #2;
      chk64("nobyp_old", ifb.RData[63:0], 64'h55);
      chk1("nobyp_busy", ifb.RBusy[0], 1'b1);
      chk64("byp_new", ifa.RData[63:0], 64'h77);
      chk1("byp_busy_forced", ifa.RBusy[0], 1'b0);
      tick();
      idle();
      #2;
      chk64("nobyp_next", ifb.RData[63:0], 64'h77);
      chk1("nobyp_busy_clr", ifb.RBusy[0], 1'b0);
      tick();

      // Out-of-range on DEPTH=24, then four distinct read ports.
      drive(1'b1, 5'd25, 64'hCAFE, 1'b0, 5'd0, 64'd0, 1'b1, 5'd25);
      ra[0] = 5'd25;
      tick();
      idle();
      #2;
      chk64("oor_b_rd", ifb.RData[63:0], 64'd0);
      chk1("oor_b_busy", ifb.RBusy[0], 1'b0);
      chk64("inr_a_rd25", ifa.RData[63:0], 64'hCAFE);
      chk1("inr_a_busy25", ifa.RBusy[0], 1'b1);
      tick();
      drive(1'b1, 5'd1, 64'h101, 1'b1, 5'd2, 64'h202, 1'b0, 5'd0);
      tick();
      drive(1'b1, 5'd3, 64'h303, 1'b1, 5'd23, 64'h2323, 1'b0, 5'd0);
      tick();
      idle();
      ra[0] = 5'd1;
      ra[1] = 5'd2;
      ra[2] = 5'd3;
      ra[3] = 5'd23;
      #2;
      chk64("b4_rd0", ifb.RData[63:0], 64'h101);
      chk64("b4_rd1", ifb.RData[127:64], 64'h202);
      chk64("b4_rd2", ifb.RData[191:128], 64'h303);
      chk64("b4_rd3", ifb.RData[255:192], 64'h2323);
      chk1("b4_rb3", ifb.RBusy[3], 1'b0);
      chk64("a2_rd0", ifa.RData[63:0], 64'h101);
      chk64("a2_rd1", ifa.RData[127:64], 64'h202);
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file: next generation of the single-cycle core's 32x64 register file.
- Adds:
  - configurable width, depth and read-port count
  - two write ports with defined priority
  - optional hard-wired zero register
  - optional write-to-read bypass
  - per-register busy scoreboard for pipelined/multi-cycle producers
- Sits between decode (read addresses, busy checks) and writeback (write ports).

Parameters:
DW, 64, data width in bits
DEPTH, 32, number of registers (2..256, need not be power of 2)
NUM_RD, 2, number of read ports (1..4)
ZERO_EN, 1, 1 = register ZERO_IDX is hard-wired zero
ZERO_IDX, 31, index of zero register (valid when ZERO_EN=1)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports
AW (localparam), clog2(DEPTH), address width

Ports:
Clk  input  1  clock, all state updates on rising edge
Rst_n  input  1  asynchronous active-low reset
RAddr  input  NUM_RD*AW  read addresses, port i at [i*AW +: AW]
RData  output  NUM_RD*DW  read data, port i at [i*DW +: DW], combinational
RBusy  output  NUM_RD  busy flag of register addressed by port i, combinational
WE0  input  1  write enable, port 0
WAddr0  input  AW  write address, port 0
WData0  input  DW  write data, port 0
WE1  input  1  write enable, port 1 (priority port)
WAddr1  input  AW  write address, port 1
WData1  input  DW  write data, port 1
BusySet  input  1  mark register BusyAddr as pending
BusyAddr  input  AW  register to mark busy

Behaviour:
Reset:
- Rst_n low asynchronously clears all registers to 0 and all busy bits to 0, regardless of Clk.
- While Rst_n is low, writes and BusySet are ignored.
- RData reads 0 and RBusy reads 0 during reset.
- Deassertion takes effect at the next rising edge.

Writes:
- Registered at the rising edge; data is visible to reads one cycle later (or the same cycle via bypass).
- Both ports enabled to the same address: port 1 wins; port 0 is dropped.
- Different addresses: both written.

Zero register (ZERO_EN=1):
- Writes to ZERO_IDX are ignored.
- Reads of ZERO_IDX return 0.
- ZERO_IDX is never busy.
- BusySet to ZERO_IDX is ignored.

Out-of-range addresses (>= DEPTH):
- Writes and BusySet are ignored.
- Reads return 0 and RBusy returns 0.

Reads:
- Pure combinational from RAddr; zero clock latency.

Bypass:
- BYPASS=1: a read port whose address matches an enabled, in-range, non-zero write this cycle returns that write data.
  - If both write ports match, WData1 is returned.
- BYPASS=0: reads return the pre-edge stored value.

Scoreboard:
- Each register has one busy bit.
- At the rising edge: an enabled write on either port clears the busy bit of its address.
- At the rising edge: BusySet sets busy[BusyAddr].
- Same address set and cleared in the same cycle: set wins (new producer issued behind retiring one).
- RBusy[i] = busy[RAddr_i].
  - With BYPASS=1, RBusy[i] is also forced 0 when an enabled write to RAddr_i occurs this cycle.
  - With BYPASS=0, no such forcing.

Reset mid-operation:
- Any pending write or BusySet in the cycle Rst_n falls is discarded.
- State is all-zero until the first edge after deassertion.

Test Plan:
- Reset then read all addresses on both ports -> RData=0, RBusy=0 everywhere; assert Rst_n low mid-run after writing 0xDEAD to r5 -> r5 reads 0 immediately, without a clock edge.
- WE0 r3=0x1111 and WE1 r3=0x2222 in the same cycle -> next cycle r3 reads 0x2222; separately WE0 r4=0xA, WE1 r6=0xB -> both stored.
- ZERO_EN=1: write 0xFFFF_FFFF_FFFF_FFFF to r31 and BusySet r31 -> r31 reads 0, RBusy=0; r30 write of the same value reads back correctly.
- BYPASS=1: RAddr0=r7 while WE1 r7=0x77 -> RData0=0x77 in that same cycle; BYPASS=0 build -> old value, then 0x77 the next cycle.
- Scoreboard: BusySet r9 -> RBusy=1 the next cycle; WE0 r9 plus BusySet r9 in the same cycle -> stays busy; a later WE1 r9 alone -> busy clears (RBusy=0 in the write cycle with BYPASS=1).
- DEPTH=24: write and read r25 -> write ignored, read 0, RBusy 0; NUM_RD=4 with all four ports on distinct registers -> each returns its own data.
